// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU: run-time power-of-two lane grouping of SEG_W-bit
// segments, three-operand add/subtract with accumulator feedback and sticky overflow.
module simd_alu_pipe #(
    parameter int SEG_W   = 4,
    parameter int NUM_SEG = 8,
    parameter int MW      = $clog2(NUM_SEG) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [MW-1:0]              simd_mode,
    input  logic [1:0]                 op,
    input  logic                       sub,
    input  logic                       acc_en,
    input  logic [SEG_W*NUM_SEG-1:0]   W,
    input  logic [SEG_W*NUM_SEG-1:0]   X,
    input  logic [SEG_W*NUM_SEG-1:0]   Y,
    input  logic [SEG_W*NUM_SEG-1:0]   Z,
    input  logic [NUM_SEG-1:0]         cin,
    input  logic                       clr_flags,
    output logic                       out_valid,
    output logic [SEG_W*NUM_SEG-1:0]   S,
    output logic [NUM_SEG-1:0]         carry_out,
    output logic [NUM_SEG-1:0]         ovf
);

    localparam int N    = SEG_W * NUM_SEG;
    localparam int LOG2 = $clog2(NUM_SEG);

    // Stage 1: captured operands and controls
    logic               v1_q;
    logic [1:0]         op_q;
    logic               sub_q;
    logic               acc_q;
    logic [MW-1:0]      mode_q;
    logic [N-1:0]       w_q, x_q, y_q, z_q;
    logic [NUM_SEG-1:0] cin_q;

    // Stage 2: result registers
    logic               vo_q, vo_d;
    logic [N-1:0]       s_q, s_d;
    logic [NUM_SEG-1:0] co_q, co_d;
    logic [NUM_SEG-1:0] ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            op_q   <= '0;
            sub_q  <= 1'b0;
            acc_q  <= 1'b0;
            mode_q <= '0;
            w_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            cin_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                op_q   <= op;
                sub_q  <= sub;
                acc_q  <= acc_en;
                mode_q <= simd_mode;
                w_q    <= W;
                x_q    <= X;
                y_q    <= Y;
                z_q    <= Z;
                cin_q  <= cin;
            end
        end
    end

    logic [N-1:0]  zeff;
    logic [MW-1:0] m_eff;

    assign zeff  = acc_q ? s_q : z_q;
    assign m_eff = (mode_q > MW'(LOG2)) ? MW'(LOG2) : mode_q;

    // Every lane size is computed in parallel; the active one is OR-selected below.
    logic [LOG2+1:0][N-1:0]       s_chain;
    logic [LOG2+1:0][NUM_SEG-1:0] co_chain;
    logic [LOG2+1:0][NUM_SEG-1:0] ov_chain;

    assign s_chain[0]  = '0;
    assign co_chain[0] = '0;
    assign ov_chain[0] = '0;

    generate
        for (genvar gm = 0; gm <= LOG2; gm++) begin : g_mode
            localparam int SPAN = 1 << gm;
            localparam int L    = SEG_W * SPAN;
            localparam int LW   = L + 3;

            logic [N-1:0]       s_m;
            logic [NUM_SEG-1:0] co_m;
            logic [NUM_SEG-1:0] ov_m;
            logic               hit;

            assign hit = (m_eff == MW'(gm));

            for (genvar gi = 0; gi < NUM_SEG / SPAN; gi++) begin : g_lane
                localparam int LO     = gi * L;
                localparam int SEG_LO = gi * SPAN;

                logic [LW-1:0] wu, xu, yu, zu;
                logic [LW-1:0] ws, xs, ys, zs;
                logic [LW-1:0] cinx, tot_u, tot_s, sum_u, dif_u, res_s;
                logic          carry;
                logic          ovf_lane;

                // Three guard bits hold the exact unsigned and signed results.
                assign wu = {3'b000, w_q[LO +: L]};
                assign xu = {3'b000, x_q[LO +: L]};
                assign yu = {3'b000, y_q[LO +: L]};
                assign zu = {3'b000, zeff[LO +: L]};
                assign ws = {{3{w_q[LO+L-1]}}, w_q[LO +: L]};
                assign xs = {{3{x_q[LO+L-1]}}, x_q[LO +: L]};
                assign ys = {{3{y_q[LO+L-1]}}, y_q[LO +: L]};
                assign zs = {{3{zeff[LO+L-1]}}, zeff[LO +: L]};
                assign cinx = LW'(cin_q[SEG_LO]);

                assign tot_u = wu + xu + yu + cinx;
                assign tot_s = ws + xs + ys + cinx;
                assign sum_u = zu + tot_u;
                assign dif_u = zu - tot_u;
                assign res_s = sub_q ? (zs - tot_s) : (zs + tot_s);

                assign carry    = sub_q ? (zu < tot_u) : (sum_u[LW-1:L] != 3'b000);
                assign ovf_lane = (res_s[LW-1:L-1] != 4'b0000) && (res_s[LW-1:L-1] != 4'b1111);

                assign s_m[LO +: L]            = sub_q ? dif_u[L-1:0] : sum_u[L-1:0];
                assign co_m[SEG_LO +: SPAN]    = SPAN'(carry) << (SPAN - 1);
                assign ov_m[SEG_LO +: SPAN]    = SPAN'(ovf_lane) << (SPAN - 1);
            end

            assign s_chain[gm+1]  = s_chain[gm]  | ({N{hit}} & s_m);
            assign co_chain[gm+1] = co_chain[gm] | ({NUM_SEG{hit}} & co_m);
            assign ov_chain[gm+1] = ov_chain[gm] | ({NUM_SEG{hit}} & ov_m);
        end
    endgenerate

    // A flag set on the same edge as clr_flags survives the clear.
    always_comb begin
        vo_d  = v1_q;
        s_d   = s_q;
        co_d  = co_q;
        ovf_d = clr_flags ? '0 : ovf_q;
        if (v1_q) begin
            case (op_q)
                2'b00: begin
                    s_d   = s_chain[LOG2+1];
                    co_d  = co_chain[LOG2+1];
                    ovf_d = ovf_d | ov_chain[LOG2+1];
                end
                2'b01: begin
                    s_d  = x_q ^ zeff;
                    co_d = '0;
                end
                2'b10: begin
                    s_d  = x_q & zeff;
                    co_d = '0;
                end
                default: begin
                    s_d  = x_q | zeff;
                    co_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vo_q  <= 1'b0;
            s_q   <= '0;
            co_q  <= '0;
            ovf_q <= '0;
        end else begin
            vo_q  <= vo_d;
            s_q   <= s_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = vo_q;
    assign S         = s_q;
    assign carry_out = co_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed-vector bench for simd_alu_pipe at SEG_W=4, NUM_SEG=8.
module tb_simd_alu_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  simd_mode;
    logic [1:0]  op;
    logic        sub;
    logic        acc_en;
    logic [31:0] W, X, Y, Z;
    logic [7:0]  cin;
    logic        clr_flags;
    logic        out_valid;
    logic [31:0] S;
    logic [7:0]  carry_out;
    logic [7:0]  ovf;

    int checks;
    int failures;

    simd_alu_pipe #(
        .SEG_W  (4),
        .NUM_SEG(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .simd_mode(simd_mode),
        .op       (op),
        .sub      (sub),
        .acc_en   (acc_en),
        .W        (W),
        .X        (X),
        .Y        (Y),
        .Z        (Z),
        .cin      (cin),
        .clr_flags(clr_flags),
        .out_valid(out_valid),
        .S        (S),
        .carry_out(carry_out),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid  = 1'b0;
        simd_mode = 4'd0;
        op        = 2'b00;
        sub       = 1'b0;
        acc_en    = 1'b0;
        W = '0; X = '0; Y = '0; Z = '0;
        cin       = '0;
        clr_flags = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        $display("txn reset out_valid=%0b S=%h carry=%h ovf=%h", out_valid, S, carry_out, ovf);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", out_valid); end
        checks++; if (S !== 32'h0) begin failures++; $display("FAIL reset_S actual=%h expected=00000000", S); end
        checks++; if (carry_out !== 8'h0) begin failures++; $display("FAIL reset_carry actual=%h expected=00", carry_out); end
        checks++; if (ovf !== 8'h0) begin failures++; $display("FAIL reset_ovf actual=%h expected=00", ovf); end
    endtask

    task automatic test_full_add;
        logic [3:0] modes [2];
        modes[0] = 4'd3;
        modes[1] = 4'd15;
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            simd_mode = modes[i];
            X = 32'h0000_0001;
            Z = 32'hFFFF_FFFF;
            in_valid = 1'b1;
            tick();
            idle_inputs();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_add_latency mode=%0d actual=%b expected=0", modes[i], out_valid); end
            tick();
            $display("txn full_add mode=%0d S=%h carry=%h ovf=%h valid=%0b", modes[i], S, carry_out, ovf, out_valid);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_add_valid mode=%0d actual=%b expected=1", modes[i], out_valid); end
            checks++; if (S !== 32'h0) begin failures++; $display("FAIL full_add_S mode=%0d actual=%h expected=00000000", modes[i], S); end
            checks++; if (carry_out !== 8'h80) begin failures++; $display("FAIL full_add_carry mode=%0d actual=%h expected=80", modes[i], carry_out); end
            checks++; if (ovf !== 8'h00) begin failures++; $display("FAIL full_add_ovf mode=%0d actual=%h expected=00", modes[i], ovf); end
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_add_pulse mode=%0d actual=%b expected=0", modes[i], out_valid); end
        end
    endtask

    task automatic issue_mode0_add;
        idle_inputs();
        simd_mode = 4'd0;
        X = 32'h1111_1111;
        Z = 32'h7777_777F;
        in_valid = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_mode0_flags;
        issue_mode0_add();
        tick();
        $display("txn mode0_add S=%h carry=%h ovf=%h", S, carry_out, ovf);
        checks++; if (S !== 32'h8888_8880) begin failures++; $display("FAIL mode0_S actual=%h expected=88888880", S); end
        checks++; if (carry_out !== 8'h01) begin failures++; $display("FAIL mode0_carry actual=%h expected=01", carry_out); end
        checks++; if (ovf !== 8'hFE) begin failures++; $display("FAIL mode0_ovf actual=%h expected=fe", ovf); end
        // clear coincides with the execute edge of the repeated op
        issue_mode0_add();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        $display("txn mode0_add_clr S=%h ovf=%h valid=%0b", S, ovf, out_valid);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mode0_clr_valid actual=%b expected=1", out_valid); end
        checks++; if (ovf !== 8'hFE) begin failures++; $display("FAIL set_wins_ovf actual=%h expected=fe", ovf); end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        $display("txn idle_clr ovf=%h valid=%0b", ovf, out_valid);
        checks++; if (ovf !== 8'h00) begin failures++; $display("FAIL idle_clr_ovf actual=%h expected=00", ovf); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_clr_valid actual=%b expected=0", out_valid); end
        checks++; if (S !== 32'h8888_8880) begin failures++; $display("FAIL idle_clr_S_hold actual=%h expected=88888880", S); end
    endtask

    task automatic test_mode1_sub;
        idle_inputs();
        simd_mode = 4'd1;
        sub = 1'b1;
        Z = 32'h0010_0500;
        X = 32'h0001_0601;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        $display("txn mode1_sub S=%h carry=%h ovf=%h", S, carry_out, ovf);
        checks++; if (S !== 32'h000F_FFFF) begin failures++; $display("FAIL mode1_sub_S actual=%h expected=000fffff", S); end
        checks++; if (carry_out !== 8'h0A) begin failures++; $display("FAIL mode1_sub_borrow actual=%h expected=0a", carry_out); end
        checks++; if (ovf !== 8'h00) begin failures++; $display("FAIL mode1_sub_ovf actual=%h expected=00", ovf); end
    endtask

    task automatic test_accumulate;
        apply_reset();
        simd_mode = 4'd3;
        X = 32'h1;
        acc_en = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i >= 2) begin
                $display("txn acc step=%0d S=%h valid=%0b", i - 1, S, out_valid);
                checks++; if (S !== 32'(i - 1)) begin failures++; $display("FAIL acc_S step=%0d actual=%h expected=%h", i - 1, S, 32'(i - 1)); end
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL acc_valid step=%0d actual=%b expected=1", i - 1, out_valid); end
            end
        end
        idle_inputs();
        tick();
        $display("txn acc step=5 S=%h valid=%0b", S, out_valid);
        checks++; if (S !== 32'd5) begin failures++; $display("FAIL acc_S step=5 actual=%h expected=00000005", S); end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (S !== 32'd5 || out_valid !== 1'b0) begin failures++; $display("FAIL acc_hold cycle=%0d actual S=%h valid=%b expected S=00000005 valid=0", j, S, out_valid); end
        end
        simd_mode = 4'd3;
        X = 32'h1;
        acc_en = 1'b1;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        $display("txn acc resume S=%h valid=%0b", S, out_valid);
        checks++; if (S !== 32'd6) begin failures++; $display("FAIL acc_resume_S actual=%h expected=00000006", S); end
    endtask

    task automatic test_logic_or;
        issue_mode0_add();
        tick();
        checks++; if (ovf !== 8'hFE) begin failures++; $display("FAIL or_pre_ovf actual=%h expected=fe", ovf); end
        idle_inputs();
        simd_mode = 4'd3;
        op  = 2'b11;
        sub = 1'b1;
        W   = 32'h1234_5678;
        Y   = 32'hFFFF_FFFF;
        cin = 8'hFF;
        X   = 32'hF0F0_0000;
        Z   = 32'h0F0F_00FF;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        $display("txn logic_or S=%h carry=%h ovf=%h", S, carry_out, ovf);
        checks++; if (S !== 32'hFFFF_00FF) begin failures++; $display("FAIL or_S actual=%h expected=ffff00ff", S); end
        checks++; if (carry_out !== 8'h00) begin failures++; $display("FAIL or_carry actual=%h expected=00", carry_out); end
        checks++; if (ovf !== 8'hFE) begin failures++; $display("FAIL or_ovf actual=%h expected=fe", ovf); end
    endtask

    task automatic test_reset_mid;
        idle_inputs();
        simd_mode = 4'd3;
        X = 32'h5;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("txn reset_mid S=%h ovf=%h valid=%0b", S, ovf, out_valid);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid actual=%b expected=0", out_valid); end
        checks++; if (S !== 32'h0) begin failures++; $display("FAIL rmid_S actual=%h expected=00000000", S); end
        checks++; if (ovf !== 8'h0) begin failures++; $display("FAIL rmid_ovf actual=%h expected=00", ovf); end
        tick();
        checks++; if (out_valid !== 1'b0 || S !== 32'h0) begin failures++; $display("FAIL rmid_dropped actual S=%h valid=%b expected S=00000000 valid=0", S, out_valid); end
        simd_mode = 4'd3;
        X = 32'h7;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_latency actual=%b expected=0", out_valid); end
        tick();
        $display("txn after_reset S=%h valid=%0b", S, out_valid);
        checks++; if (S !== 32'h7 || out_valid !== 1'b1) begin failures++; $display("FAIL rmid_next actual S=%h valid=%b expected S=00000007 valid=1", S, out_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_full_add();
        test_mode0_flags();
        test_mode1_sub();
        test_accumulate();
        test_logic_or();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
